// File: rtl/alu_cond_unit.sv
// Condition evaluation and NZCV flag register with a LIFO save/restore stack.
// Gates the execute-stage write strobes on the condition result.
module alu_cond_unit #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ex_valid,
    input  logic [3:0] ex_cond,
    input  logic [1:0] ex_flag_w,
    input  logic       ex_reg_w,
    input  logic       ex_mem_w,
    input  logic       ex_pcs,
    input  logic [3:0] alu_flags,
    input  logic       push,
    input  logic       pop,
    output logic       cond_ex,
    output logic       reg_write,
    output logic       mem_write,
    output logic       pc_src,
    output logic [3:0] flags,
    output logic       stk_full,
    output logic       stk_empty,
    output logic       stk_err
);

    localparam int PW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    // ARM-style condition decode over {N,Z,C,V}; 4'hF is reserved and never passes.
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v, res;
        {n, z, c, v} = f;
        case (cond)
            4'h0:    res = z;
            4'h1:    res = ~z;
            4'h2:    res = c;
            4'h3:    res = ~c;
            4'h4:    res = n;
            4'h5:    res = ~n;
            4'h6:    res = v;
            4'h7:    res = ~v;
            4'h8:    res = c & ~z;
            4'h9:    res = ~c | z;
            4'hA:    res = (n == v);
            4'hB:    res = (n != v);
            4'hC:    res = ~z & (n == v);
            4'hD:    res = z | (n != v);
            4'hE:    res = 1'b1;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    logic [3:0]    flags_r;
    logic [PW-1:0] count_r;
    logic          err_r;
    logic [3:0]    stack_r [DEPTH];

    logic          cond_ok_s;
    logic          full_s;
    logic          empty_s;
    logic          illegal_s;
    logic          push_ok_s;
    logic          pop_ok_s;
    logic [IW-1:0] wr_idx_s;
    logic [IW-1:0] rd_idx_s;
    logic [3:0]    flags_next_s;
    logic [PW-1:0] count_next_s;

    // Condition result, stack status and next-state selection.
    always_comb begin
        cond_ok_s    = cond_pass(ex_cond, flags_r);
        full_s       = (count_r == PW'(DEPTH));
        empty_s      = (count_r == {PW{1'b0}});
        illegal_s    = (push & pop) | (push & full_s) | (pop & empty_s);
        push_ok_s    = push & ~pop & ~full_s;
        pop_ok_s     = pop & ~push & ~empty_s;
        wr_idx_s     = count_r[IW-1:0];
        rd_idx_s     = IW'(count_r - PW'(1));
        flags_next_s = flags_r;
        count_next_s = count_r;
        if (ex_valid & cond_ok_s) begin
            if (ex_flag_w[1]) begin
                flags_next_s[3:2] = alu_flags[3:2];
            end else begin
                flags_next_s[3:2] = flags_r[3:2];
            end
            if (ex_flag_w[0]) begin
                flags_next_s[1:0] = alu_flags[1:0];
            end else begin
                flags_next_s[1:0] = flags_r[1:0];
            end
        end else begin
            flags_next_s = flags_r;
        end
        // A successful pop restores the saved flags over any ALU update.
        if (pop_ok_s) begin
            flags_next_s = stack_r[rd_idx_s];
            count_next_s = count_r - PW'(1);
        end else if (push_ok_s) begin
            count_next_s = count_r + PW'(1);
        end else begin
            count_next_s = count_r;
        end
    end

    // Flag register, stack pointer and error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_r <= 4'b0000;
            count_r <= {PW{1'b0}};
            err_r   <= 1'b0;
        end else begin
            flags_r <= flags_next_s;
            count_r <= count_next_s;
            err_r   <= illegal_s;
        end
    end

    // Stack storage needs no reset: entries above the pointer are never read.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            stack_r[wr_idx_s] <= flags_r;
        end
    end

    assign cond_ex   = cond_ok_s;
    assign reg_write = ex_reg_w & cond_ok_s & ex_valid;
    assign mem_write = ex_mem_w & cond_ok_s & ex_valid;
    assign pc_src    = ex_pcs & cond_ok_s & ex_valid;
    assign flags     = flags_r;
    assign stk_full  = full_s;
    assign stk_empty = empty_s;
    assign stk_err   = err_r;

endmodule

// File: tb/tb_alu_cond_unit.sv
// Bench for alu_cond_unit: directed literal checks followed by random traffic
// compared every cycle against a queue-based flag/stack model.
module tb_alu_cond_unit;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ex_valid = 1'b0;
    logic [3:0] ex_cond = 4'h0;
    logic [1:0] ex_flag_w = 2'b00;
    logic       ex_reg_w = 1'b0;
    logic       ex_mem_w = 1'b0;
    logic       ex_pcs = 1'b0;
    logic [3:0] alu_flags = 4'h0;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic       cond_ex, reg_write, mem_write, pc_src;
    logic [3:0] flags;
    logic       stk_full, stk_empty, stk_err;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference state: architectural flags, saved-flag LIFO, pending error.
    logic [3:0] m_flags = 4'h0;
    logic [3:0] m_stk[$];
    logic       m_err = 1'b0;

    alu_cond_unit #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_cond(ex_cond),
        .ex_flag_w(ex_flag_w), .ex_reg_w(ex_reg_w), .ex_mem_w(ex_mem_w),
        .ex_pcs(ex_pcs), .alu_flags(alu_flags), .push(push), .pop(pop),
        .cond_ex(cond_ex), .reg_write(reg_write), .mem_write(mem_write),
        .pc_src(pc_src), .flags(flags), .stk_full(stk_full),
        .stk_empty(stk_empty), .stk_err(stk_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic bit ref_cond(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v;
        bit tbl[16];
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        tbl[0]  = z;          tbl[1]  = !z;
        tbl[2]  = cy;         tbl[3]  = !cy;
        tbl[4]  = n;          tbl[5]  = !n;
        tbl[6]  = v;          tbl[7]  = !v;
        tbl[8]  = cy && !z;   tbl[9]  = !cy || z;
        tbl[10] = (n == v);   tbl[11] = (n != v);
        tbl[12] = !z && (n == v);
        tbl[13] = z || (n != v);
        tbl[14] = 1'b1;       tbl[15] = 1'b0;
        return tbl[c];
    endfunction

    // Per-cycle compare at the falling edge, then advance the model to the next edge.
    always @(negedge clk) begin
        bit c, ill;
        logic [3:0] nf;
        if (rst) begin
            m_flags = 4'h0;
            m_stk.delete();
            m_err = 1'b0;
        end
        c = ref_cond(ex_cond, m_flags);
        check("cond_ex",   {3'b000, cond_ex},   {3'b000, c});
        check("reg_write", {3'b000, reg_write}, {3'b000, ex_valid & ex_reg_w & c});
        check("mem_write", {3'b000, mem_write}, {3'b000, ex_valid & ex_mem_w & c});
        check("pc_src",    {3'b000, pc_src},    {3'b000, ex_valid & ex_pcs & c});
        check("flags",     flags, m_flags);
        check("stk_full",  {3'b000, stk_full},  {3'b000, m_stk.size() == DEPTH});
        check("stk_empty", {3'b000, stk_empty}, {3'b000, m_stk.size() == 0});
        check("stk_err",   {3'b000, stk_err},   {3'b000, m_err});
        if (!rst) begin
            ill = (push && pop) || (push && m_stk.size() == DEPTH) || (pop && m_stk.size() == 0);
            nf = m_flags;
            if (ex_valid && c) begin
                if (ex_flag_w[1]) nf[3:2] = alu_flags[3:2];
                if (ex_flag_w[0]) nf[1:0] = alu_flags[1:0];
            end
            if (!ill && push) m_stk.push_back(m_flags);
            if (!ill && pop) nf = m_stk.pop_back();
            m_flags = nf;
            m_err = ill;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set(input logic v, input logic [3:0] cnd, input logic [1:0] fw,
                       input logic [3:0] alu, input logic pu, input logic po);
        ex_valid = v; ex_cond = cnd; ex_flag_w = fw; alu_flags = alu;
        push = pu; pop = po; ex_reg_w = 1'b0; ex_mem_w = 1'b0; ex_pcs = 1'b0;
    endtask

    task automatic idle();
        set(1'b0, 4'h0, 2'b00, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic load(input logic [3:0] f);
        tick(); set(1'b1, 4'hE, 2'b11, f, 1'b0, 1'b0);
        tick(); idle();
    endtask

    task automatic chk_cond(input string name, input logic [3:0] cnd, input logic exp);
        tick(); set(1'b0, cnd, 2'b00, 4'h0, 1'b0, 1'b0);
        #1 check(name, {3'b000, cond_ex}, {3'b000, exp});
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        // Reset state and condition decode on Q = 0000
        check("rst_flags", flags, 4'h0);
        check("rst_empty", {3'b000, stk_empty}, 4'h1);
        chk_cond("eq_z0", 4'h0, 1'b0);
        chk_cond("ne_z0", 4'h1, 1'b1);
        chk_cond("rsvd",  4'hF, 1'b0);
        chk_cond("al",    4'hE, 1'b1);
        tick(); set(1'b0, 4'hE, 2'b00, 4'h0, 1'b0, 1'b0); ex_reg_w = 1'b1;
        #1 check("rw_invalid", {3'b000, reg_write}, 4'h0);
        // Flag load through AL, then EQ gates writes
        tick(); set(1'b1, 4'hE, 2'b11, 4'b0100, 1'b0, 1'b0);
        tick(); set(1'b1, 4'h0, 2'b00, 4'h0, 1'b0, 1'b0); ex_reg_w = 1'b1;
        #1 check("load_0100", flags, 4'b0100);
        check("rw_eq", {3'b000, reg_write}, 4'h1);
        tick(); set(1'b1, 4'h0, 2'b11, 4'b0000, 1'b0, 1'b0);
        tick(); idle();
        #1 check("load_0000", flags, 4'b0000);
        // Signed/unsigned compares and partial update
        load(4'b1000);
        chk_cond("ge", 4'hA, 1'b0);
        chk_cond("lt", 4'hB, 1'b1);
        chk_cond("gt", 4'hC, 1'b0);
        chk_cond("le", 4'hD, 1'b1);
        load(4'b0010);
        chk_cond("hi", 4'h8, 1'b1);
        chk_cond("ls", 4'h9, 1'b0);
        load(4'b1010);
        tick(); set(1'b1, 4'hE, 2'b10, 4'b0111, 1'b0, 1'b0);
        tick(); idle();
        #1 check("nz_only", flags, 4'b0110);
        // Save/restore with pop overriding an ALU update
        load(4'b0011);
        tick(); set(1'b0, 4'h0, 2'b00, 4'h0, 1'b1, 1'b0);
        tick(); idle();
        load(4'b1100);
        tick(); set(1'b0, 4'h0, 2'b00, 4'h0, 1'b1, 1'b0);
        tick(); set(1'b1, 4'hE, 2'b11, 4'b0000, 1'b0, 1'b1);
        tick(); idle();
        #1 check("pop_ovr", flags, 4'b1100);
        tick(); set(1'b0, 4'h0, 2'b00, 4'h0, 1'b0, 1'b1);
        tick(); idle();
        #1 check("pop2", flags, 4'b0011);
        check("pop2_empty", {3'b000, stk_empty}, 4'h1);
        // Full, overflow, underflow, simultaneous push/pop
        for (int i = 0; i < DEPTH; i++) begin
            tick(); set(1'b0, 4'h0, 2'b00, 4'h0, 1'b1, 1'b0);
        end
        tick(); idle();
        #1 check("full", {3'b000, stk_full}, 4'h1);
        tick(); set(1'b0, 4'h0, 2'b00, 4'h0, 1'b1, 1'b0);
        tick(); idle();
        #1 check("ovf_err", {3'b000, stk_err}, 4'h1);
        check("ovf_full", {3'b000, stk_full}, 4'h1);
        tick();
        check("ovf_err_end", {3'b000, stk_err}, 4'h0);
        for (int i = 0; i < DEPTH; i++) begin
            tick(); set(1'b0, 4'h0, 2'b00, 4'h0, 1'b0, 1'b1);
        end
        tick(); set(1'b0, 4'h0, 2'b00, 4'h0, 1'b0, 1'b1);
        tick(); idle();
        #1 check("unf_err", {3'b000, stk_err}, 4'h1);
        tick(); set(1'b0, 4'h0, 2'b00, 4'h0, 1'b1, 1'b1);
        tick(); idle();
        #1 check("pp_err", {3'b000, stk_err}, 4'h1);
        check("pp_empty", {3'b000, stk_empty}, 4'h1);
        // Asynchronous reset in the middle of a push
        load(4'b1011);
        for (int i = 0; i < 2; i++) begin
            tick(); set(1'b0, 4'h0, 2'b00, 4'h0, 1'b1, 1'b0);
        end
        tick(); set(1'b0, 4'h0, 2'b00, 4'h0, 1'b1, 1'b0);
        #1 rst = 1'b1;
        #1 check("arst_flags", flags, 4'h0);
        check("arst_empty", {3'b000, stk_empty}, 4'h1);
        check("arst_err", {3'b000, stk_err}, 4'h0);
        idle();
        tick();
        rst = 1'b0;
        // Random traffic, stack ops biased so full/empty are both reached
        for (int i = 0; i < 3000; i++) begin
            tick();
            rst = ($urandom_range(0, 199) == 0);
            set($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
                2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
            ex_reg_w = 1'($urandom_range(0, 1));
            ex_mem_w = 1'($urandom_range(0, 1));
            ex_pcs   = 1'($urandom_range(0, 1));
        end
        tick();
        rst = 1'b0;
        idle();
        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
